// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for EX: shift-add multiply, restoring divide.
// Ports: clk, reset, clk_en, start, op, operand_a/b, wr_hi/wr_lo/wr_data, mf_req -> busy, stall_req, done, hi, lo.
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             mf_req,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIXUP, WB} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               b_zero;
  logic [WIDTH-1:0]   bm;
  logic [WIDTH-1:0]   ah;
  logic [WIDTH-1:0]   al;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic [WIDTH-1:0]   nxt_hi;
  logic [WIDTH-1:0]   nxt_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign busy      = (state != IDLE);
  assign stall_req = busy & (mf_req | start | wr_hi | wr_lo);

  assign signed_op = ~op[0];
  assign a_mag = (signed_op & operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign b_mag = (signed_op & operand_b[WIDTH-1]) ? -operand_b : operand_b;

  // ah:al is the product (mul) or remainder:quotient (div) shift pair
  always_comb begin
    mul_sum = {1'b0, ah} + (al[0] ? {1'b0, bm} : '0);
    shifted = {ah, al[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, bm};
    nxt_hi  = mul_sum[WIDTH:1];
    nxt_lo  = {mul_sum[0], al[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH+1]) begin
        nxt_hi = diff[WIDTH-1:0];
        nxt_lo = {al[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = shifted[WIDTH-1:0];
        nxt_lo = {al[WIDTH-2:0], 1'b0};
      end
    end
  end

  // A zero divisor leaves |a| as remainder; the dividend-sign fix
  // restores the original operand_a, quotient is forced to all ones.
  always_comb begin
    prod = {ah, al};
    if (neg_res) prod = -prod;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div) begin
      fix_hi = neg_rem ? -ah : ah;
      if (b_zero)       fix_lo = '1;
      else if (neg_res) fix_lo = -al;
      else              fix_lo = al;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      bm      <= '0;
      ah      <= '0;
      al      <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else if (clk_en) begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            cnt     <= '0;
            is_div  <= op[1];
            neg_res <= signed_op & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            neg_rem <= signed_op & operand_a[WIDTH-1];
            b_zero  <= (operand_b == '0);
            bm      <= op[1] ? b_mag : a_mag;
            al      <= op[1] ? a_mag : b_mag;
            ah      <= '0;
          end else begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
          end
        end
        RUN: begin
          ah  <= nxt_hi;
          al  <= nxt_lo;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) state <= FIXUP;
        end
        FIXUP: begin
          ah    <= fix_hi;
          al    <= fix_lo;
          state <= WB;
        end
        WB: begin
          hi    <= ah;
          lo    <= al;
          done  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
